// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle control FSM: state encoding,
// opcodes, ALU operation classes and trap cause codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BREX    = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11,
    S_JALEX   = 4'd12,
    S_TRAP    = 4'd13,
    S_HALT    = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_FN  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Logical immediates are zero-extended, arithmetic ones sign-extended.
  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle controller (master) and the datapath /
// memory side (slave): opcode and memory handshake in, strobes and selects out.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       pcwrite;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       branch;
  logic       brne;
  logic       iord;
  logic       immext;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [2:0] aluop;
  logic       trap;
  logic [1:0] cause;
  logic       halted;
  logic [3:0] state_o;

  modport master (
    input  op, mem_ready,
    output mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
           brne, iord, immext, alusrcb, pcsrc, regdst, memtoreg, aluop,
           trap, cause, halted, state_o
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
           brne, iord, immext, alusrcb, pcsrc, regdst, memtoreg, aluop,
           trap, cause, halted, state_o
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory-wait timeout counter; expired flags the stalled cycle in which the
// count would reach all-ones.
module mc_wait_timer #(
  parameter int TO_W = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = ~TO_W'(1);

  logic [TO_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + TO_W'(1);
    end
  end

  // A ready response in this cycle suppresses inc, so it always wins the race.
  assign expired = inc && (cnt_reg == LAST);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control FSM with memory-wait timeout and trap/halt.
// Define MC_CTRL_JAL_EN to decode JAL; otherwise opcode 000011 is illegal.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int TO_W         = 4,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  mc_ctrl_fsm_if.master bus
);

  state_t     state_reg, state_next;
  logic [1:0] cause_reg, cause_next;
  logic       in_wait, wait_inc, timeout;

  assign in_wait  = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                    (state_reg == S_MEMWR);
  assign wait_inc = in_wait && !bus.mem_ready;

  // Outside the wait states the counter is held cleared, which covers every entry.
  mc_wait_timer #(.TO_W(TO_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!wait_inc),
    .inc     (wait_inc),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
      cause_reg <= CAUSE_NONE;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    case (state_reg)
      S_FETCH: begin
        if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (bus.mem_ready) begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:                     state_next = S_MEMADR;
          OP_RTYPE:                         state_next = S_RTYPEEX;
          OP_BEQ, OP_BNE:                   state_next = S_BREX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IMMEX;
          OP_J:                             state_next = S_JEX;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:                           state_next = S_JALEX;
`endif
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:  state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (bus.mem_ready) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWR: begin
        if (timeout) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end else if (bus.mem_ready) begin
          state_next = S_FETCH;
        end
      end
      S_RTYPEEX: state_next = S_ALUWB;
      S_IMMEX:   state_next = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BREX, S_IMMWB, S_JEX: state_next = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JALEX:   state_next = S_FETCH;
`endif
      S_TRAP: begin
        // A bus timeout is never recoverable; illegal opcodes depend on ILLEGAL_HALT.
        if ((ILLEGAL_HALT != 0) || (cause_reg == CAUSE_TIMEOUT)) state_next = S_HALT;
        else                                                     state_next = S_FETCH;
      end
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.branch   = 1'b0;
    bus.brne     = 1'b0;
    bus.iord     = 1'b0;
    bus.immext   = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.regdst   = 2'b00;
    bus.memtoreg = 2'b00;
    bus.aluop    = ALU_ADD;
    bus.trap     = 1'b0;
    bus.halted   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
      end
      S_DECODE:  bus.alusrcb = 2'b11;
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 2'b01;
      end
      S_MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALU_FN;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 2'b01;
      end
      S_BREX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALU_SUB;
        bus.pcsrc   = 2'b01;
        bus.branch  = 1'b1;
        bus.brne    = (bus.op == OP_BNE);
      end
      S_IMMEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop   = imm_aluop(bus.op);
        bus.immext  = imm_zero_ext(bus.op);
      end
      S_IMMWB:   bus.regwrite = 1'b1;
      S_JEX: begin
        bus.pcwrite = 1'b1;
        bus.pcsrc   = 2'b10;
      end
`ifdef MC_CTRL_JAL_EN
      S_JALEX: begin
        bus.pcwrite  = 1'b1;
        bus.pcsrc    = 2'b10;
        bus.regwrite = 1'b1;
        bus.regdst   = 2'b10;
        bus.memtoreg = 2'b10;
      end
`endif
      S_TRAP:    bus.trap   = 1'b1;
      S_HALT:    bus.halted = 1'b1;
      default: ;
    endcase
    // Reset holds state in FETCH; keep its request and write strobes quiet until release.
    if (!reset_n) begin
      bus.mem_req  = 1'b0;
      bus.irwrite  = 1'b0;
      bus.pcwrite  = 1'b0;
      bus.memwrite = 1'b0;
      bus.regwrite = 1'b0;
    end
  end

  assign bus.cause   = cause_reg;
  assign bus.state_o = state_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed per-cycle expectations are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic mem_req, irwrite, pcwrite, memwrite, regwrite, alusrca, branch, brne,
          iord, immext, trap, halted;
    logic [1:0] alusrcb, pcsrc, regdst, memtoreg, cause;
    logic [2:0] aluop;
  } snap_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  snap_t exp_q[$];
  bit    who_q[$];
  string name_q[$];

  mc_ctrl_fsm_if bus_a();
  mc_ctrl_fsm_if bus_b();

  mc_ctrl_fsm #(.TO_W(4), .ILLEGAL_HALT(0)) dut_a (.clk(clk), .reset_n(rst_a), .bus(bus_a));
  mc_ctrl_fsm #(.TO_W(2), .ILLEGAL_HALT(1)) dut_b (.clk(clk), .reset_n(rst_b), .bus(bus_b));

  always #5 clk = ~clk;

  snap_t act_a, act_b;
  assign act_a = {bus_a.state_o, bus_a.mem_req, bus_a.irwrite, bus_a.pcwrite, bus_a.memwrite,
                  bus_a.regwrite, bus_a.alusrca, bus_a.branch, bus_a.brne, bus_a.iord,
                  bus_a.immext, bus_a.trap, bus_a.halted, bus_a.alusrcb, bus_a.pcsrc,
                  bus_a.regdst, bus_a.memtoreg, bus_a.cause, bus_a.aluop};
  assign act_b = {bus_b.state_o, bus_b.mem_req, bus_b.irwrite, bus_b.pcwrite, bus_b.memwrite,
                  bus_b.regwrite, bus_b.alusrca, bus_b.branch, bus_b.brne, bus_b.iord,
                  bus_b.immext, bus_b.trap, bus_b.halted, bus_b.alusrcb, bus_b.pcsrc,
                  bus_b.regdst, bus_b.memtoreg, bus_b.cause, bus_b.aluop};

  // Expected-value builders, one per state, written from the output table.
  function automatic snap_t b(input state_t s, input logic [1:0] c);
    snap_t e;
    e = '0;
    e.st = s;
    e.cause = c;
    return e;
  endfunction
  function automatic snap_t e_rst();
    snap_t e = b(S_FETCH, 2'b00);
    e.alusrcb = 2'b01;
    return e;
  endfunction
  function automatic snap_t e_fetch(input logic r, input logic [1:0] c);
    snap_t e = b(S_FETCH, c);
    e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = r; e.pcwrite = r;
    return e;
  endfunction
  function automatic snap_t e_decode(input logic [1:0] c);
    snap_t e = b(S_DECODE, c);
    e.alusrcb = 2'b11;
    return e;
  endfunction
  function automatic snap_t e_memadr(input logic [1:0] c);
    snap_t e = b(S_MEMADR, c);
    e.alusrca = 1'b1; e.alusrcb = 2'b10;
    return e;
  endfunction
  function automatic snap_t e_memrd(input logic [1:0] c);
    snap_t e = b(S_MEMRD, c);
    e.mem_req = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic snap_t e_memwb(input logic [1:0] c);
    snap_t e = b(S_MEMWB, c);
    e.regwrite = 1'b1; e.memtoreg = 2'b01;
    return e;
  endfunction
  function automatic snap_t e_memwr(input logic [1:0] c);
    snap_t e = b(S_MEMWR, c);
    e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1;
    return e;
  endfunction
  function automatic snap_t e_rtex(input logic [1:0] c);
    snap_t e = b(S_RTYPEEX, c);
    e.alusrca = 1'b1; e.aluop = 3'b010;
    return e;
  endfunction
  function automatic snap_t e_aluwb(input logic [1:0] c);
    snap_t e = b(S_ALUWB, c);
    e.regwrite = 1'b1; e.regdst = 2'b01;
    return e;
  endfunction
  function automatic snap_t e_brex(input logic ne, input logic [1:0] c);
    snap_t e = b(S_BREX, c);
    e.alusrca = 1'b1; e.aluop = 3'b001; e.pcsrc = 2'b01; e.branch = 1'b1; e.brne = ne;
    return e;
  endfunction
  function automatic snap_t e_immex(input logic [2:0] aop, input logic ix, input logic [1:0] c);
    snap_t e = b(S_IMMEX, c);
    e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = aop; e.immext = ix;
    return e;
  endfunction
  function automatic snap_t e_immwb(input logic [1:0] c);
    snap_t e = b(S_IMMWB, c);
    e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic snap_t e_jex(input logic [1:0] c);
    snap_t e = b(S_JEX, c);
    e.pcwrite = 1'b1; e.pcsrc = 2'b10;
    return e;
  endfunction
  function automatic snap_t e_jalex(input logic [1:0] c);
    snap_t e = b(S_JALEX, c);
    e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.regwrite = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
    return e;
  endfunction
  function automatic snap_t e_trap(input logic [1:0] c);
    snap_t e = b(S_TRAP, c);
    e.trap = 1'b1;
    return e;
  endfunction
  function automatic snap_t e_halt(input logic [1:0] c);
    snap_t e = b(S_HALT, c);
    e.halted = 1'b1;
    return e;
  endfunction

  // Called just after a posedge: drive mem_ready, queue this cycle's expectation.
  task automatic step(input bit w, input logic rdy, input snap_t e, input string n);
    if (w) bus_b.mem_ready = rdy;
    else   bus_a.mem_ready = rdy;
    exp_q.push_back(e);
    who_q.push_back(w);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e, a;
      bit    w;
      string n;
      e = exp_q.pop_front();
      w = who_q.pop_front();
      n = name_q.pop_front();
      a = w ? act_b : act_a;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: actual st=%0d bits=%h required st=%0d bits=%h", n, a.st, a, e.st, e);
      end else begin
        $display("[TB] %s ok st=%0d", n, a.st);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.op = 6'b001000; bus_a.mem_ready = 1'b0;
    bus_b.op = 6'b001000; bus_b.mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset holds FETCH with strobes and request quiet, even with mem_ready high.
    step(0, 1, e_rst(), "rst_a0");
    step(0, 1, e_rst(), "rst_a1");
    rst_a = 1'b1;

    // ADDI, memory always ready.
    step(0, 1, e_fetch(1, 2'b00), "addi_fetch");
    step(0, 1, e_decode(2'b00), "addi_decode");
    step(0, 1, e_immex(3'b000, 0, 2'b00), "addi_immex");
    step(0, 1, e_immwb(2'b00), "addi_immwb");

    // LW with three stall cycles in MEMRD.
    bus_a.op = 6'b100011;
    step(0, 1, e_fetch(1, 2'b00), "lw_fetch");
    step(0, 1, e_decode(2'b00), "lw_decode");
    step(0, 1, e_memadr(2'b00), "lw_memadr");
    for (int i = 0; i < 3; i++) step(0, 0, e_memrd(2'b00), "lw_memrd_wait");
    step(0, 1, e_memrd(2'b00), "lw_memrd_done");
    step(0, 1, e_memwb(2'b00), "lw_memwb");

    // SW with one stall cycle.
    bus_a.op = 6'b101011;
    step(0, 1, e_fetch(1, 2'b00), "sw_fetch");
    step(0, 1, e_decode(2'b00), "sw_decode");
    step(0, 1, e_memadr(2'b00), "sw_memadr");
    step(0, 0, e_memwr(2'b00), "sw_memwr_wait");
    step(0, 1, e_memwr(2'b00), "sw_memwr_done");

    bus_a.op = 6'b000101;
    step(0, 1, e_fetch(1, 2'b00), "bne_fetch");
    step(0, 1, e_decode(2'b00), "bne_decode");
    step(0, 1, e_brex(1, 2'b00), "bne_brex");
    bus_a.op = 6'b000100;
    step(0, 1, e_fetch(1, 2'b00), "beq_fetch");
    step(0, 1, e_decode(2'b00), "beq_decode");
    step(0, 1, e_brex(0, 2'b00), "beq_brex");

    bus_a.op = 6'b001101;
    step(0, 1, e_fetch(1, 2'b00), "ori_fetch");
    step(0, 1, e_decode(2'b00), "ori_decode");
    step(0, 1, e_immex(3'b100, 1, 2'b00), "ori_immex");
    step(0, 1, e_immwb(2'b00), "ori_immwb");
    bus_a.op = 6'b001100;
    step(0, 1, e_fetch(1, 2'b00), "andi_fetch");
    step(0, 1, e_decode(2'b00), "andi_decode");
    step(0, 1, e_immex(3'b011, 1, 2'b00), "andi_immex");
    step(0, 1, e_immwb(2'b00), "andi_immwb");
    bus_a.op = 6'b001010;
    step(0, 1, e_fetch(1, 2'b00), "slti_fetch");
    step(0, 1, e_decode(2'b00), "slti_decode");
    step(0, 1, e_immex(3'b101, 0, 2'b00), "slti_immex");
    step(0, 1, e_immwb(2'b00), "slti_immwb");

    bus_a.op = 6'b000000;
    step(0, 1, e_fetch(1, 2'b00), "rtype_fetch");
    step(0, 1, e_decode(2'b00), "rtype_decode");
    step(0, 1, e_rtex(2'b00), "rtype_ex");
    step(0, 1, e_aluwb(2'b00), "rtype_aluwb");

    // J, preceded by two fetch stalls (well under the TO_W=4 limit).
    bus_a.op = 6'b000010;
    step(0, 0, e_fetch(0, 2'b00), "j_fetch_wait0");
    step(0, 0, e_fetch(0, 2'b00), "j_fetch_wait1");
    step(0, 1, e_fetch(1, 2'b00), "j_fetch");
    step(0, 1, e_decode(2'b00), "j_decode");
    step(0, 1, e_jex(2'b00), "j_jex");

    // Illegal opcode, ILLEGAL_HALT=0: trap then refetch, cause latched to 01.
    bus_a.op = 6'b111111;
    step(0, 1, e_fetch(1, 2'b00), "ill_fetch");
    step(0, 1, e_decode(2'b00), "ill_decode");
    step(0, 1, e_trap(2'b01), "ill_trap");

    bus_a.op = 6'b000011;
    step(0, 1, e_fetch(1, 2'b01), "jal_fetch");
    step(0, 1, e_decode(2'b01), "jal_decode");
`ifdef MC_CTRL_JAL_EN
    step(0, 1, e_jalex(2'b01), "jal_jalex");
`else
    step(0, 1, e_trap(2'b01), "jal_illegal_trap");
`endif

    // Reset asserted mid-MEMWR drops memwrite and returns to FETCH without a clock.
    bus_a.op = 6'b101011;
    step(0, 1, e_fetch(1, 2'b01), "rstw_fetch");
    step(0, 1, e_decode(2'b01), "rstw_decode");
    step(0, 1, e_memadr(2'b01), "rstw_memadr");
    step(0, 0, e_memwr(2'b01), "rstw_memwr");
    rst_a = 1'b0;
    step(0, 0, e_rst(), "rstw_async");
    step(0, 1, e_rst(), "rstw_held");
    rst_a = 1'b1;
    step(0, 1, e_fetch(1, 2'b00), "rstw_refetch");

    // dut_b: TO_W=2, memory stuck in FETCH -> timeout after 3 cycles, then HALT.
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, e_fetch(0, 2'b00), "to_fetch_wait");
    step(1, 1, e_trap(2'b10), "to_trap");
    step(1, 1, e_halt(2'b10), "to_halt0");
    step(1, 1, e_halt(2'b10), "to_halt1");
    rst_b = 1'b0;
    step(1, 1, e_rst(), "rst_b");
    rst_b = 1'b1;

    // Ready arrives in the very cycle the count would hit all-ones: no timeout.
    step(1, 0, e_fetch(0, 2'b00), "edge_fetch_wait0");
    step(1, 0, e_fetch(0, 2'b00), "edge_fetch_wait1");
    step(1, 1, e_fetch(1, 2'b00), "edge_fetch_done");
    step(1, 1, e_decode(2'b00), "edge_decode");
    step(1, 1, e_immex(3'b000, 0, 2'b00), "edge_immex");
    step(1, 1, e_immwb(2'b00), "edge_immwb");

    // Illegal opcode with ILLEGAL_HALT=1 parks in HALT.
    bus_b.op = 6'b111111;
    step(1, 1, e_fetch(1, 2'b00), "illh_fetch");
    step(1, 1, e_decode(2'b00), "illh_decode");
    step(1, 1, e_trap(2'b01), "illh_trap");
    step(1, 1, e_halt(2'b01), "illh_halt0");
    step(1, 0, e_halt(2'b01), "illh_halt1");

    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter TO_W, default 4: memory-wait timeout counter width; timeout at 2**TO_W-1 cycles.
REQ-002 Parameter ILLEGAL_HALT, default 0: 1 = illegal opcode parks in HALT; 0 = trap then refetch.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 op  in  6  opcode from instruction register; stable outside FETCH.
REQ-006 mem_ready  in  1  memory accepts/returns current access this cycle.
REQ-007 mem_req  out  1  memory access request.
REQ-008 pcwrite, memwrite, irwrite, regwrite, alusrca, branch, brne, iord, immext  out  1 each  datapath strobes/selects.
REQ-009 alusrcb, pcsrc, regdst, memtoreg  out  2 each  mux selects.
REQ-010 aluop  out  3  ALU operation class.
REQ-011 trap  out  1  one-cycle exception pulse; cause  out  2  latched cause (01 illegal, 10 bus timeout).
REQ-012 halted  out  1  FSM parked in HALT; state_o  out  4  current state, debug.

Function
REQ-013 Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, J 000010, JAL 000011; any other opcode is illegal.
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BREX, IMMEX, IMMWB, JEX, JALEX, TRAP, HALT.
REQ-015 Outputs are Moore-decoded from state, plus op in BREX/IMMEX and mem_ready in memory states; unlisted outputs are 0.
REQ-016 FETCH: mem_req=1, alusrcb=01, aluop=000; irwrite=pcwrite=mem_ready; -> DECODE when mem_ready, else stay.
REQ-017 DECODE: alusrcb=11, aluop=000; -> MEMADR (LW/SW), RTYPEEX, BREX (BEQ/BNE), IMMEX (ADDI/ANDI/ORI/SLTI), JEX, JALEX, else TRAP (cause 01).
REQ-018 MEMADR: alusrca=1, alusrcb=10, aluop=000; -> MEMRD (LW) or MEMWR (SW).
REQ-019 MEMRD: mem_req=1, iord=1; -> MEMWB on mem_ready. MEMWB: regwrite=1, memtoreg=01, regdst=00; -> FETCH.
REQ-020 MEMWR: mem_req=1, iord=1, memwrite=1 held until mem_ready; -> FETCH on mem_ready.
REQ-021 RTYPEEX: alusrca=1, alusrcb=00, aluop=010; -> ALUWB. ALUWB: regwrite=1, regdst=01; -> FETCH.
REQ-022 BREX: alusrca=1, aluop=001, pcsrc=01, branch=1, brne=1 iff BNE; -> FETCH.
REQ-023 IMMEX: alusrca=1, alusrcb=10; aluop ADDI 000, ANDI 011, ORI 100, SLTI 101; immext=1 for ANDI/ORI only; -> IMMWB. IMMWB: regwrite=1, regdst=00; -> FETCH.
REQ-024 JEX: pcwrite=1, pcsrc=10; -> FETCH. JALEX: pcwrite=1, pcsrc=10, regwrite=1, regdst=10, memtoreg=10; -> FETCH.
REQ-025 Wait counter: clears on entry to FETCH/MEMRD/MEMWR and on mem_ready; increments each cycle in those states with mem_ready=0; on reaching all-ones -> TRAP, cause 10, no strobe issued.
REQ-026 mem_ready in the same cycle as counter reaching all-ones: access completes, no timeout.
REQ-027 TRAP: trap=1 for exactly one cycle; -> HALT if ILLEGAL_HALT=1 or cause=10, else FETCH.
REQ-028 HALT: halted=1, all strobes 0; exits only via reset.
REQ-029 cause updates only on TRAP entry; holds otherwise.

Reset
REQ-030 reset_n low: state=FETCH, wait counter=0, cause=00, trap=0, halted=0, immediately and asynchronously, including mid-access.
REQ-031 While reset_n low: irwrite, pcwrite, memwrite, regwrite forced 0 irrespective of mem_ready.
REQ-032 First FETCH request issues on the first posedge after reset_n deasserts.

Configuration
REQ-033 Macro MC_CTRL_JAL_EN defined: JAL decodes to JALEX per REQ-024.
REQ-034 Macro MC_CTRL_JAL_EN undefined: JALEX absent, opcode 000011 treated as illegal (TRAP, cause 01).

Structure
REQ-035 Package mc_ctrl_pkg holds the state enum (4-bit), opcode constants, aluop constants, and cause codes.
REQ-036 Sub-module mc_wait_timer (TO_W-bit counter, clear/inc/expired) instantiated once.

Verification
REQ-037 Reset release, op=ADDI, mem_ready=1 -> states FETCH,DECODE,IMMEX,IMMWB,FETCH; regwrite=1 only in IMMWB.
REQ-038 LW with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB once, memtoreg=01.
REQ-039 TO_W=2, mem_ready stuck 0 in FETCH -> TRAP after 3 cycles, trap pulse, cause=10, then HALT.
REQ-040 op=111111, ILLEGAL_HALT=0 -> DECODE,TRAP,FETCH, cause=01; with 1 -> HALT, halted=1.
REQ-041 op=BNE -> BREX with branch=1, brne=1, pcsrc=01; op=ORI -> IMMEX aluop=100, immext=1.
REQ-042 reset_n pulsed low in MEMWR with memwrite=1 -> memwrite 0 immediately, state FETCH; JAL illegal when MC_CTRL_JAL_EN undefined.
